// File: rtl/rv32i_id_stage_if.sv
// rtl/rv32i_id_stage_if.sv - fetch/regfile/writeback/execute signal bundle for the RV32I decode stage
interface rv32i_id_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_illegal;

  // ID stage side
  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2,
           wb_we, wb_waddr, wb_wdata, ex_ready,
    output if_ready, rf_raddr1, rf_raddr2,
           id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_rs1, id_rs2,
           id_opcode, id_funct3, id_funct7b5, id_illegal
  );

  // surrounding pipeline side
  modport master (
    output if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2,
           wb_we, wb_waddr, wb_wdata, ex_ready,
    input  if_ready, rf_raddr1, rf_raddr2,
           id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_rs1, id_rs2,
           id_opcode, id_funct3, id_funct7b5, id_illegal
  );
endinterface

// File: rtl/rv32i_id_stage.sv
// rtl/rv32i_id_stage.sv - RV32I decode stage with load-use interlock; RV32I_ID_WB_BYPASS_EN selects writeback bypass over stall
module rv32i_id_stage #(
  parameter logic [31:0] BUBBLE_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rstn,
  rv32i_id_stage_if.slave pipe
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        illegal;
  logic        rs1_used;
  logic        rs2_used;
  logic        hazard;
  logic        wb_hit1;
  logic        wb_hit2;
  logic        wbstall;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        accept;

  assign instr  = pipe.if_instr;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign pipe.rf_raddr1 = rs1;
  assign pipe.rf_raddr2 = rs2;

  // immediate extraction and legality by major opcode
  always_comb begin
    imm     = 32'h0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'h000};
      OP_JAL:           imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_OPIMM, OP_MISC, OP_SYSTEM:
                        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:         imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_OP:            imm = 32'h0;
      default:          illegal = 1'b1;
    endcase
  end

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // a load still sitting in ID cannot forward its result; the consumer waits one cycle
  assign hazard = pipe.id_valid && (pipe.id_opcode == OP_LOAD) && (pipe.id_rd != 5'd0) &&
                  ((rs1_used && rs1 == pipe.id_rd) || (rs2_used && rs2 == pipe.id_rd));

  // register file is written at the edge, so a same-cycle read would see the old value
  assign wb_hit1 = pipe.wb_we && (rs1 != 5'd0) && (rs1 == pipe.wb_waddr);
  assign wb_hit2 = pipe.wb_we && (rs2 != 5'd0) && (rs2 == pipe.wb_waddr);

`ifdef RV32I_ID_WB_BYPASS_EN
  assign wbstall = 1'b0;
  assign op1 = (rs1 == 5'd0) ? 32'h0 : (wb_hit1 ? pipe.wb_wdata : pipe.rf_rdata1);
  assign op2 = (rs2 == 5'd0) ? 32'h0 : (wb_hit2 ? pipe.wb_wdata : pipe.rf_rdata2);
`else
  assign wbstall = wb_hit1 || wb_hit2;
  assign op1 = (rs1 == 5'd0) ? 32'h0 : pipe.rf_rdata1;
  assign op2 = (rs2 == 5'd0) ? 32'h0 : pipe.rf_rdata2;
`endif

  assign pipe.if_ready = !pipe.flush && !hazard && !wbstall && (!pipe.id_valid || pipe.ex_ready);
  assign accept        = pipe.if_valid && pipe.if_ready;

  // ID register: flush wins, otherwise advance when EX drains or ID is empty, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe.id_valid    <= 1'b0;
      pipe.id_pc       <= BUBBLE_PC;
      pipe.id_rs1_val  <= 32'h0;
      pipe.id_rs2_val  <= 32'h0;
      pipe.id_imm      <= 32'h0;
      pipe.id_rd       <= 5'd0;
      pipe.id_rs1      <= 5'd0;
      pipe.id_rs2      <= 5'd0;
      pipe.id_opcode   <= 7'd0;
      pipe.id_funct3   <= 3'd0;
      pipe.id_funct7b5 <= 1'b0;
      pipe.id_illegal  <= 1'b0;
    end else if (pipe.flush) begin
      pipe.id_valid <= 1'b0;
    end else if (!pipe.id_valid || pipe.ex_ready) begin
      pipe.id_valid <= accept;
      if (accept) begin
        pipe.id_pc       <= pipe.if_pc;
        pipe.id_rs1_val  <= op1;
        pipe.id_rs2_val  <= op2;
        pipe.id_imm      <= imm;
        pipe.id_rd       <= instr[11:7];
        pipe.id_rs1      <= rs1;
        pipe.id_rs2      <= rs2;
        pipe.id_opcode   <= opcode;
        pipe.id_funct3   <= instr[14:12];
        pipe.id_funct7b5 <= instr[30];
        pipe.id_illegal  <= illegal;
      end
    end
  end
endmodule

// File: doc/rv32i_id_stage.md
RV32I_ID_STAGE -- requirements
Module: rv32i_id_stage

Interface
REQ-001 SHALL have parameter BUBBLE_PC, default 32'h0000_0000, value driven on id_pc at reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_valid input 1, if_instr input 32, if_pc input 32: fetched instruction offer.
REQ-005 SHALL have port if_ready  output  1  ID accepts the offer this cycle.
REQ-006 SHALL have port flush  input  1  discard the ID contents and refuse the current offer.
REQ-007 SHALL have ports rf_raddr1, rf_raddr2 output 5 and rf_rdata1, rf_rdata2 input 32: combinational register-file read interface.
REQ-008 SHALL have ports wb_we input 1, wb_waddr input 5, wb_wdata input 32: the writeback port that also feeds the register file.
REQ-009 SHALL have port ex_ready  input  1  EX accepts id_* this cycle.
REQ-010 SHALL have registered outputs id_valid 1, id_pc 32, id_rs1_val 32, id_rs2_val 32, id_imm 32, id_rd 5, id_rs1 5, id_rs2 5, id_opcode 7, id_funct3 3, id_funct7b5 1, id_illegal 1.

Function
REQ-011 SHALL drive rf_raddr1 = if_instr[19:15] and rf_raddr2 = if_instr[24:20] combinationally.
REQ-012 SHALL sign-extend immediates per format (I, S, B, U, J), with id_imm = 0 for R-type and illegal opcodes.
REQ-013 SHALL set id_illegal when the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, or SYSTEM.
REQ-014 SHALL treat rs1 as used by every opcode except LUI, AUIPC and JAL, and rs2 as used by OP, STORE and BRANCH only.
REQ-015 SHALL raise the load-use hazard when id_valid, id_opcode = LOAD, id_rd != 0, and a used rs of if_instr equals id_rd.
REQ-016 SHALL drive if_ready = !flush && !hazard && !wbstall && (!id_valid || ex_ready).
REQ-017 SHALL update state at the clock edge by priority: flush clears id_valid; else, when !id_valid || ex_ready, id_valid <= if_valid && if_ready, and all id_* load the decoded fields on acceptance; else all id_* hold.
REQ-018 SHALL hold every id_* value stable while id_valid && !ex_ready.
REQ-019 SHALL emit exactly one bubble (id_valid = 0) per load-use hazard, after which the instruction is accepted.
REQ-020 SHALL capture 0 for an operand whose rs index is 0, regardless of rf_rdata or the bypass.

Reset
REQ-021 SHALL, while rstn = 0, force id_valid = 0, id_pc = BUBBLE_PC, and all other id_* outputs to 0.
REQ-022 SHALL drop a held instruction when reset asserts mid-stall, and SHALL accept a new one no earlier than the first edge after rstn deasserts.

Configuration
REQ-023 SHALL, with RV32I_ID_WB_BYPASS_EN defined, capture wb_wdata instead of rf_rdata for any operand whose nonzero rs equals wb_waddr while wb_we = 1, with wbstall = 0.
REQ-024 SHALL, without RV32I_ID_WB_BYPASS_EN, set wbstall = 1 under the same match condition, stalling exactly one cycle and then capturing rf_rdata.

Verification
REQ-025 SHALL show that ADDI x5,x1,-1 (0xFFF08293) at pc 0x100, with x1 = 7 and ex_ready = 1, gives the next cycle id_valid = 1, id_pc = 0x100, id_rs1_val = 7, id_imm = 0xFFFFFFFF, id_rd = 5.
REQ-026 SHALL show that LW x3,0(x2) followed by ADD x4,x3,x3 gives one bubble cycle with if_ready = 0, after which ADD is accepted.
REQ-027 SHALL show that writing x6 = 0xDEAD_BEEF at wb while SUB x7,x6,x0 is offered gives id_rs1_val = 0xDEADBEEF with zero stall cycles under the macro, and one stall cycle without it.
REQ-028 SHALL show that holding ex_ready = 0 for 3 cycles with if_valid = 1 keeps if_ready = 0 and all id_* unchanged.
REQ-029 SHALL show that asserting flush together with a valid offer gives id_valid = 0 next cycle, with the offer not consumed.
REQ-030 SHALL show that opcode 7'b1111111 gives id_illegal = 1 and id_imm = 0, and that a write of x0 via wb_we with waddr 0 still gives id_rs1_val = 0.
